// File: rtl/cam_fb_writer.sv
// Camera frame-buffer writer: filters capture-stage pixel strobes for one frame,
// computes linear addresses and queues them in a small FIFO drained by the memory.
//
// state  | meaning
// IDLE   | after reset, waiting for the first vsync high
// SYNC   | vertical blanking, waiting for vsync low to start a frame
// ACTIVE | capturing pixels into the write FIFO
// FLUSH  | frame ended, draining the FIFO before signalling frame_done
module cam_fb_writer #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic        cam_vsync,
   input  logic        wren,
   input  logic [9:0]  next_x,
   input  logic [9:0]  next_y,
   input  logic [17:0] rgb,
   input  logic        half_res,
   input  logic        mem_ready,
   output logic        mem_we,
   output logic [18:0] mem_addr,
   output logic [17:0] mem_data,
   output logic        frame_done,
   output logic        overflow,
   output logic [15:0] drop_count,
   output logic [7:0]  frame_count
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int EW = 19 + 18;
   localparam logic [9:0]  H_LIM    = 10'(H_ACTIVE);
   localparam logic [9:0]  V_LIM    = 10'(V_ACTIVE);
   localparam logic [18:0] H_FULL   = 19'(H_ACTIVE);
   localparam logic [18:0] H_HALF   = 19'(H_ACTIVE / 2);
   localparam logic [AW:0] CNT_FULL = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SYNC   = 2'd1,
      ACTIVE = 2'd2,
      FLUSH  = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic          half_lat;
   logic [EW-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   fifo_cnt;
   logic          fifo_empty, fifo_full;
   logic [EW-1:0] head;

   logic          frame_start, flush_done;
   logic          pix_in_range, pix_decim_ok, accept;
   logic          push, pop, drop;
   logic [18:0]   addr_full, addr_half, push_addr;

   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == CNT_FULL);
   assign head       = fifo_mem[rd_ptr];

   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      flush_done  = 1'b0;
      case (state)
         IDLE:   if (cam_vsync) state_nxt = SYNC;
         SYNC:   if (!cam_vsync) begin
                    state_nxt   = ACTIVE;
                    frame_start = 1'b1;
                 end
         ACTIVE: if (cam_vsync) state_nxt = FLUSH;
         FLUSH:  if (fifo_empty) begin
                    state_nxt  = SYNC;
                    flush_done = 1'b1;
                 end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pix_in_range = (next_x < H_LIM) && (next_y < V_LIM);
      pix_decim_ok = !half_lat || (!next_x[0] && !next_y[0]);
      accept       = (state == ACTIVE) && wren && pix_in_range && pix_decim_ok;
      addr_full    = 19'(next_y) * H_FULL + 19'(next_x);
      addr_half    = 19'(next_y[9:1]) * H_HALF + 19'(next_x[9:1]);
      push_addr    = half_lat ? addr_half : addr_full;
      pop          = !fifo_empty && mem_ready;
      // a full FIFO still takes the pixel when its head leaves in the same cycle
      push         = accept && (!fifo_full || pop);
      drop         = accept && !push;
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         state       <= IDLE;
         half_lat    <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_cnt    <= '0;
         overflow    <= 1'b0;
         drop_count  <= '0;
         frame_count <= '0;
         frame_done  <= 1'b0;
      end else begin
         state      <= state_nxt;
         frame_done <= flush_done;
         if (flush_done) frame_count <= frame_count + 8'd1;
         if (frame_start) begin
            half_lat   <= half_res;
            overflow   <= 1'b0;
            drop_count <= '0;
         end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         end
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
            2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge pclk) begin
      if (push) fifo_mem[wr_ptr] <= {push_addr, rgb};
   end

   // storage is not reset, so the outputs are forced to zero when nothing is presented
   assign mem_we   = !fifo_empty && !reset;
   assign mem_addr = mem_we ? head[EW-1:18] : '0;
   assign mem_data = mem_we ? head[17:0]    : '0;

endmodule

// File: doc/cam_fb_writer.md
CAM_FB_WRITER -- requirements
Module: cam_fb_writer

Interface
REQ-001 Parameter: H_ACTIVE, 640, active pixels per line.
REQ-002 Parameter: V_ACTIVE, 480, active lines per frame.
REQ-003 Parameter: FIFO_DEPTH, 4, write-FIFO entries; power of two, minimum 2.
REQ-004 Port: pclk  input  1  sole clock; all logic on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: cam_vsync  input  1  camera frame sync; high between frames.
REQ-007 Port: wren  input  1  capture-stage pixel strobe; single-cycle per pixel.
REQ-008 Port: next_x  input  10  column of the strobed pixel.
REQ-009 Port: next_y  input  10  row of the strobed pixel.
REQ-010 Port: rgb  input  18  pixel data from the capture stage.
REQ-011 Port: half_res  input  1  1 = store 320x240 decimated frame; 0 = full frame.
REQ-012 Port: mem_ready  input  1  frame-buffer memory accepts a write this cycle.
REQ-013 Port: mem_we  output  1  write request; high while a FIFO entry is presented.
REQ-014 Port: mem_addr  output  19  linear frame-buffer word address.
REQ-015 Port: mem_data  output  18  pixel word to write.
REQ-016 Port: frame_done  output  1  one-cycle pulse after a frame is fully written.
REQ-017 Port: overflow  output  1  sticky; a pixel was dropped in the current frame.
REQ-018 Port: drop_count  output  16  dropped pixels in the current frame, saturating.
REQ-019 Port: frame_count  output  8  completed frames, wrapping.

Function
REQ-020 States: IDLE, SYNC, ACTIVE, FLUSH.
REQ-021 IDLE -> SYNC when cam_vsync = 1.
REQ-022 SYNC -> ACTIVE when cam_vsync = 0; on this transition half_res is latched for the frame, and overflow and drop_count clear to 0.
REQ-023 ACTIVE -> FLUSH when cam_vsync = 1.
REQ-024 FLUSH -> SYNC in the cycle after the FIFO becomes empty; that same cycle pulses frame_done and increments frame_count, wrapping 255 -> 0.
REQ-025 A pixel is accepted only in ACTIVE, with wren = 1, next_x < H_ACTIVE and next_y < V_ACTIVE; other strobes are ignored and are not counted as drops.
REQ-026 With latched half_res = 1, only pixels with next_x[0] = 0 and next_y[0] = 0 are accepted; the others are ignored.
REQ-027 Full-resolution address: next_y*H_ACTIVE + next_x (range 0..307199).
REQ-028 Half-resolution address: (next_y>>1)*(H_ACTIVE/2) + (next_x>>1) (range 0..76799).
REQ-029 Address arithmetic uses at least 19 bits with no truncation; the address is computed at push time and stored with rgb in the FIFO.
REQ-030 Push occurs on an accepted pixel when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-031 An accepted pixel that cannot be pushed is dropped: overflow is set, drop_count increments, and drop_count saturates at 65535.
REQ-032 mem_we = FIFO not empty; mem_addr and mem_data show the head entry and stay stable until popped.
REQ-033 Pop occurs when mem_we = 1 and mem_ready = 1; the next entry is presented on the following cycle.
REQ-034 Latency: a pixel accepted in cycle n with the FIFO empty gives mem_we = 1 with its address and data in cycle n+1.
REQ-035 Writes leave in strict acceptance order; no entry is duplicated or lost except by REQ-031.
REQ-036 In FLUSH, no new pixels are accepted and the FIFO drains under mem_ready.
REQ-037 In IDLE and SYNC, no pixels are accepted.

Reset
REQ-038 Reset (any state, including mid-frame or mid-flush) sends the state to IDLE and empties the FIFO.
REQ-039 Reset drives mem_we, frame_done and overflow to 0, and drop_count and frame_count to 0.
REQ-040 During reset, mem_addr and mem_data read 0.

Verification
REQ-041 Full-res frame, mem_ready = 1: vsync 1->0, strobes at (0,0), (639,0), (5,479) -> writes at addr 0, 639, 306565 one cycle after each strobe; vsync 1 -> frame_done pulse, frame_count = 1.
REQ-042 Half-res: half_res = 1 at frame start, strobes (2,2), (3,2), (2,3), (638,478) -> exactly two writes, at addr 321 and 76799.
REQ-043 Backpressure: mem_ready = 0, 6 accepted strobes -> first 4 held in order, overflow = 1, drop_count = 2; mem_ready = 1 -> the 4 held entries write in order.
REQ-044 Full FIFO with mem_ready = 1 and a strobe in the same cycle -> pixel pushed, drop_count unchanged.
REQ-045 Flush: vsync rises with 3 entries queued and mem_ready = 0 for 5 cycles -> no frame_done until the 3rd write, then one pulse; the next frame clears overflow.
REQ-046 Reset mid-frame with 2 entries queued -> next cycle mem_we = 0, state IDLE, counters 0; strobes before the next vsync 1->0 are ignored.
